// File: rtl/spmv_tile_scheduler.sv
// Tile scheduler for the SpMV core: fetches value, column and vector words per tile, then starts the core on the tile.
// Optional performance counters are built when SPMV_SCHED_PERF_EN is defined.
module spmv_tile_scheduler #(
    parameter int ADDR_W    = 16,
    parameter int BUF_DEPTH = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [135:0]      i_row_ptr,
    input  logic [ADDR_W-1:0] i_val_base,
    input  logic [ADDR_W-1:0] i_col_base,
    input  logic [ADDR_W-1:0] i_vec_base,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_core_start,
    input  logic [2:0]        i_core_state,
    output logic [15:0]       o_core_data_A,
    output logic [15:0]       o_core_data_B,
    output logic [7:0]        o_core_count,
    output logic [135:0]      o_core_row_ptr,
    output logic              o_done,
`ifdef SPMV_SCHED_PERF_EN
    output logic [31:0]       o_perf_mem_wait,
    output logic [31:0]       o_perf_run,
`endif
    output logic              o_busy
);

    localparam int K_W = $clog2(BUF_DEPTH);
    localparam logic [2:0] CORE_IDLE  = 3'd0;
    localparam logic [2:0] CORE_WRITE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_VAL,
        S_F_COL,
        S_F_VEC,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [135:0]      row_ptr_q;
    logic [ADDR_W-1:0] val_base;
    logic [ADDR_W-1:0] col_base;
    logic [ADDR_W-1:0] vec_base;
    logic [ADDR_W-1:0] col_q;
    logic [7:0]        count;
    logic [7:0]        tile_start;
    logic [K_W-1:0]    entry;
    logic              wait_rv;
    logic              seen_write;

    logic [15:0] buf_a [BUF_DEPTH];
    logic [15:0] buf_b [BUF_DEPTH];

    logic [7:0]     nnz;
    logic [7:0]     idx;
    logic           last_entry;
    logic [K_W-1:0] run_off;
    logic           accept;
    logic           issue;
    logic           rdone;

    assign nnz        = row_ptr_q[135:128];
    assign idx        = tile_start + 8'(entry);
    // Same finish rule as the core: tile ends on the last nonzero or on a nonzero multiple of 16.
    assign last_entry = (idx == nnz - 8'd1) || ((idx != 8'd0) && (idx[3:0] == 4'd0));
    assign run_off    = K_W'(count - tile_start);
    assign accept     = i_job_valid && (state == S_IDLE);
    assign issue      = o_mem_req && i_mem_gnt;
    assign rdone      = wait_rv && i_mem_rvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;
        o_core_start = 1'b0;
        o_done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_job_valid) begin
                    state_next = (i_row_ptr[135:128] == 8'd0) ? S_DONE : S_F_VAL;
                end
            end
            S_F_VAL: begin
                o_mem_req  = !wait_rv;
                o_mem_addr = val_base + ADDR_W'(idx);
                if (rdone) state_next = S_F_COL;
            end
            S_F_COL: begin
                o_mem_req  = !wait_rv;
                o_mem_addr = col_base + ADDR_W'(idx);
                if (rdone) state_next = S_F_VEC;
            end
            S_F_VEC: begin
                o_mem_req  = !wait_rv;
                o_mem_addr = vec_base + col_q;
                if (rdone) state_next = last_entry ? S_START : S_F_VAL;
            end
            S_START: begin
                if (i_core_state == CORE_IDLE) begin
                    o_core_start = 1'b1;
                    state_next   = S_RUN;
                end
            end
            S_RUN: begin
                if ((i_core_state == CORE_IDLE) && seen_write) begin
                    state_next = (count == nnz) ? S_DONE : S_F_VAL;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_ptr_q  <= '0;
            val_base   <= '0;
            col_base   <= '0;
            vec_base   <= '0;
            col_q      <= '0;
            count      <= '0;
            tile_start <= '0;
            entry      <= '0;
            wait_rv    <= 1'b0;
            seen_write <= 1'b0;
        end else begin
            if (accept) begin
                row_ptr_q  <= i_row_ptr;
                val_base   <= i_val_base;
                col_base   <= i_col_base;
                vec_base   <= i_vec_base;
                count      <= '0;
                tile_start <= '0;
                entry      <= '0;
            end
            if (issue) begin
                wait_rv <= 1'b1;
            end else if (rdone) begin
                wait_rv <= 1'b0;
            end
            if (rdone && (state == S_F_COL)) begin
                col_q <= i_mem_rdata[ADDR_W-1:0];
            end
            if (rdone && (state == S_F_VEC) && !last_entry) begin
                entry <= entry + K_W'(1);
            end
            if (state == S_START) begin
                seen_write <= 1'b0;
            end
            // The core returning to IDLE after a WRITE marks the end of the tile.
            if (state == S_RUN) begin
                if (i_core_state == CORE_WRITE) begin
                    count      <= count + 8'd1;
                    seen_write <= 1'b1;
                end else if ((i_core_state == CORE_IDLE) && seen_write) begin
                    tile_start <= count;
                    entry      <= '0;
                    seen_write <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (rdone && (state == S_F_VAL)) begin
            buf_a[entry] <= i_mem_rdata;
        end
        if (rdone && (state == S_F_VEC)) begin
            buf_b[entry] <= i_mem_rdata;
        end
    end

    assign o_core_data_A  = (state == S_RUN) ? buf_a[run_off] : 16'd0;
    assign o_core_data_B  = (state == S_RUN) ? buf_b[run_off] : 16'd0;
    assign o_core_count   = count;
    assign o_core_row_ptr = row_ptr_q;
    assign o_busy         = (state != S_IDLE);
    assign o_job_ready    = (state == S_IDLE);

`ifdef SPMV_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_mem_wait;
    logic [31:0] perf_run;

    always_ff @(posedge i_clk) begin
        if (i_rst || accept) begin
            perf_mem_wait <= '0;
            perf_run      <= '0;
        end else begin
            if ((o_mem_req && !i_mem_gnt) || (wait_rv && !i_mem_rvalid)) begin
                perf_mem_wait <= sat_inc(perf_mem_wait);
            end
            if (state == S_RUN) begin
                perf_run <= sat_inc(perf_run);
            end
        end
    end

    assign o_perf_mem_wait = perf_mem_wait;
    assign o_perf_run      = perf_run;
`endif

endmodule

// File: tb/tb_spmv_tile_scheduler.sv
// Randomized bench for spmv_tile_scheduler with a memory responder, a core model and a job-level reference model.
module tb_spmv_tile_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [135:0] row_ptr;
    logic [15:0]  val_base;
    logic [15:0]  col_base;
    logic [15:0]  vec_base;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [15:0]  mem_rdata;
    logic         core_start;
    logic [2:0]   core_state;
    logic [15:0]  data_a;
    logic [15:0]  data_b;
    logic [7:0]   core_count;
    logic [135:0] core_row_ptr;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    spmv_tile_scheduler #(.ADDR_W(16), .BUF_DEPTH(17)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_job_valid    (job_valid),
        .o_job_ready    (job_ready),
        .i_row_ptr      (row_ptr),
        .i_val_base     (val_base),
        .i_col_base     (col_base),
        .i_vec_base     (vec_base),
        .o_mem_req      (mem_req),
        .o_mem_addr     (mem_addr),
        .i_mem_gnt      (mem_gnt),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .o_core_start   (core_start),
        .i_core_state   (core_state),
        .o_core_data_A  (data_a),
        .o_core_data_B  (data_b),
        .o_core_count   (core_count),
        .o_core_row_ptr (core_row_ptr),
        .o_done         (done),
        .o_busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents and job description
    logic [15:0] mem [0:65535];
    logic [15:0] jv [256];
    logic [15:0] jc [256];
    logic [15:0] jvec [64];
    logic [15:0] vb, cb, xb;
    int          cur_nnz = 0;

    logic [15:0] exp_addr [$];
    logic [31:0] exp_pair [$];
    logic [7:0]  exp_cnt  [$];

    int gnt_delay = 0;
    int rd_lat    = 1;
    int n_reads = 0, n_starts = 0, n_req_cycles = 0, n_accepts = 0;

    function automatic int tiles_for(input int n);
        int t = 0;
        for (int e = 0; e < n; e++) begin
            if (e == n - 1 || (e != 0 && e % 16 == 0)) t++;
        end
        return t;
    endfunction

    task automatic load_job(input int nnz);
        cur_nnz = nnz;
        vb = 16'h1000 + 16'($urandom_range(0, 255));
        cb = 16'h3000 + 16'($urandom_range(0, 255));
        xb = 16'h6000 + 16'($urandom_range(0, 255));
        for (int i = 0; i < nnz; i++) begin
            jv[i] = 16'($urandom());
            jc[i] = 16'($urandom_range(0, 63));
        end
        for (int j = 0; j < 64; j++) jvec[j] = 16'($urandom());
    endtask

    task automatic set_fixed3();
        jv[0] = 16'h3C00; jv[1] = 16'h4000; jv[2] = 16'h4200;
        jc[0] = 16'd0;    jc[1] = 16'd1;    jc[2] = 16'd2;
        jvec[0] = 16'h3C00; jvec[1] = 16'h3C00; jvec[2] = 16'h4000;
    endtask

    task automatic write_mem();
        for (int i = 0; i < cur_nnz; i++) begin
            mem[vb + 16'(i)] = jv[i];
            mem[cb + 16'(i)] = jc[i];
        end
        for (int j = 0; j < 64; j++) mem[xb + 16'(j)] = jvec[j];
    endtask

    // Reference: three reads per nonzero in index order, one operand pair and one WRITE per nonzero.
    task automatic push_expect();
        for (int i = 0; i < cur_nnz; i++) begin
            exp_addr.push_back(vb + 16'(i));
            exp_addr.push_back(cb + 16'(i));
            exp_addr.push_back(xb + jc[i]);
            exp_pair.push_back({jv[i], jvec[jc[i][5:0]]});
            exp_cnt.push_back(8'(i));
        end
    endtask

    // Memory responder: grant after gnt_delay waiting cycles, rvalid rd_lat cycles after grant.
    initial begin
        bit          pend = 0;
        bit          holding = 0;
        int          lat_cnt = 0;
        int          wait_cnt = 0;
        logic [15:0] held_addr = '0;
        logic [15:0] pend_addr = '0;
        logic [15:0] e;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #2;
            mem_gnt = 0; mem_rvalid = 0;
            if (rst) begin
                pend = 0; holding = 0; wait_cnt = 0;
            end else begin
                if (pend) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        mem_rvalid = 1; mem_rdata = mem[pend_addr]; pend = 0;
                    end
                end
                if (mem_req) begin
                    n_req_cycles++;
                    check("one_outstanding", pend || mem_rvalid, 1'b0);
                    if (!holding) begin
                        holding = 1; held_addr = mem_addr; wait_cnt = 0;
                    end else begin
                        check("addr_stable", mem_addr, held_addr);
                    end
                    if (wait_cnt >= gnt_delay) begin
                        mem_gnt = 1; holding = 0; pend = 1; lat_cnt = rd_lat;
                        pend_addr = mem_addr; n_reads++;
                        e = 16'hxxxx;
                        if (exp_addr.size() > 0) e = exp_addr.pop_front();
                        check("read_addr", mem_addr, e);
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Core model: LOAD/MUL/ADD/WRITE per nonzero, back to IDLE at the end of a tile.
    initial begin
        logic [2:0]  cs = 3'd0;
        bit          start_seen;
        logic [7:0]  wcnt;
        logic [31:0] ep;
        logic [7:0]  ec;
        core_state = 3'd0;
        forever begin
            @(negedge clk);
            start_seen = core_start;
            wcnt = core_count;
            if (!rst) begin
                if (core_start) begin
                    n_starts++;
                    check("start_when_idle", core_state, 3'd0);
                end
                if (cs == 3'd2) begin
                    ep = 32'hxxxxxxxx;
                    if (exp_pair.size() > 0) ep = exp_pair.pop_front();
                    check("core_operands", {data_a, data_b}, ep);
                end
                if (cs == 3'd4) begin
                    ec = 8'hxx;
                    if (exp_cnt.size() > 0) ec = exp_cnt.pop_front();
                    check("write_count", core_count, ec);
                end
            end
            @(posedge clk); #2;
            if (rst) begin
                cs = 3'd0;
            end else begin
                case (cs)
                    3'd0: if (start_seen) cs = 3'd1;
                    3'd1: cs = 3'd2;
                    3'd2: cs = 3'd3;
                    3'd3: cs = 3'd4;
                    default: cs = (int'(wcnt) == cur_nnz - 1 || (wcnt != 0 && wcnt % 16 == 0)) ? 3'd0 : 3'd1;
                endcase
            end
            core_state = cs;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (job_valid && job_ready) n_accepts++;
                check("ready_vs_busy", job_ready, !busy);
            end
        end
    end

    task automatic issue_job();
        @(posedge clk); #1;
        for (int t = 0; t < 200 && !job_ready; t++) begin
            @(posedge clk); #1;
        end
        check("ready_before_issue", job_ready, 1'b1);
        row_ptr  = {8'(cur_nnz), $urandom(), $urandom(), $urandom(), $urandom()};
        val_base = vb; col_base = cb; vec_base = xb;
        job_valid = 1;
        @(posedge clk); #1;
        job_valid = 0;
    endtask

    task automatic wait_done(output bit got);
        got = 0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic run_job(input int nnz, input int gd, input int lat, input bit fixed3);
        int reads0, starts0, req0, acc0;
        bit got;
        gnt_delay = gd; rd_lat = lat;
        load_job(nnz);
        if (fixed3) set_fixed3();
        write_mem();
        push_expect();
        reads0 = n_reads; starts0 = n_starts; req0 = n_req_cycles; acc0 = n_accepts;
        issue_job();
        if (nnz == 0) begin
            @(negedge clk); check("nnz0_done", done, 1'b1);
            @(negedge clk); check("nnz0_done_width", done, 1'b0);
            check("nnz0_req_cycles", n_req_cycles - req0, 0);
        end else begin
            wait_done(got);
            check("done_seen", got, 1'b1);
            @(negedge clk); check("done_width", done, 1'b0);
        end
        check("ready_after", job_ready, 1'b1);
        check("read_count", n_reads - reads0, 3 * nnz);
        check("starts", n_starts - starts0, tiles_for(nnz));
        check("accepts", n_accepts - acc0, 1);
        check("final_count", core_count, nnz);
        check("row_ptr_held", core_row_ptr, row_ptr);
        check("leftover", exp_addr.size() + exp_pair.size() + exp_cnt.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int reads0, starts0, acc0;
        rst = 1; job_valid = 0; row_ptr = '0;
        val_base = '0; col_base = '0; vec_base = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_ready", job_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_start", core_start, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", core_count, 8'd0);
        check("rst_row_ptr", core_row_ptr, 136'd0);

        run_job(0, 0, 1, 0);
        run_job(3, 0, 1, 1);
        run_job(20, 0, 1, 0);
        run_job(20, 3, 2, 0);
        run_job(3, 3, 2, 1);
        for (int r = 0; r < 6; r++) begin
            run_job($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(1, 3), 0);
        end
        run_job(255, 0, 1, 0);

        // Reset during F_COL of the second tile
        gnt_delay = 0; rd_lat = 1;
        load_job(20); write_mem(); push_expect();
        reads0 = n_reads;
        issue_job();
        got = 0;
        for (int t = 0; t < 3000; t++) begin
            if ((n_reads - reads0 == 52) && mem_req) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach_tile2_fcol", got, 1'b1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_addr.delete(); exp_pair.delete(); exp_cnt.delete();
        @(negedge clk);
        check("abort_ready", job_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_req", mem_req, 1'b0);
        check("abort_addr", mem_addr, 16'd0);
        check("abort_count", core_count, 8'd0);
        check("abort_row_ptr", core_row_ptr, 136'd0);
        check("abort_data", {data_a, data_b}, 32'd0);
        check("abort_done_start", {done, core_start}, 2'b00);
        run_job(1, 1, 2, 0);

        // Job valid held high across two acceptance windows
        gnt_delay = 0; rd_lat = 1;
        load_job(4); write_mem(); push_expect(); push_expect();
        reads0 = n_reads; starts0 = n_starts; acc0 = n_accepts;
        @(posedge clk); #1;
        row_ptr  = {8'd4, $urandom(), $urandom(), $urandom(), $urandom()};
        val_base = vb; col_base = cb; vec_base = xb;
        job_valid = 1;
        wait_done(got);
        check("hold_done1", got, 1'b1);
        check("hold_accepts_busy", n_accepts - acc0, 1);
        got = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (n_accepts - acc0 == 2) begin
                got = 1;
                break;
            end
        end
        check("hold_reaccept", got, 1'b1);
        @(posedge clk); #1;
        job_valid = 0;
        wait_done(got);
        check("hold_done2", got, 1'b1);
        repeat (4) @(negedge clk);
        check("hold_accepts", n_accepts - acc0, 2);
        check("hold_reads", n_reads - reads0, 24);
        check("hold_starts", n_starts - starts0, 2);
        check("hold_ready", job_ready, 1'b1);
        check("hold_leftover", exp_addr.size() + exp_pair.size() + exp_cnt.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spmv_tile_scheduler.md
Name: spmv_tile_scheduler

Overview:
- Sequences the SpMV core for one CSR job.
- Fetches nonzero values, column indices and vector elements from a single shared read port into a local tile buffer.
- Starts the core once per tile and drives its `count`, row-pointer and operand inputs while the core cycles LOAD/MUL/ADD/WRITE.
- Sits between the job front-end (CSR descriptor source) and the core plus its operand memory.

Parameters:
- ADDR_W, 16, memory word-address width.
- BUF_DEPTH, 17, tile buffer entries; the maximum tile length, since the first tile covers indices 0..16.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous reset, active-high
- i_job_valid  input  1  job descriptor valid
- o_job_ready  output  1  scheduler idle, can accept a job
- i_row_ptr  input  136  CSR row pointers, 17 x 8 bit; nnz = i_row_ptr[135:128]
- i_val_base  input  ADDR_W  base address of the value array
- i_col_base  input  ADDR_W  base address of the column-index array
- i_vec_base  input  ADDR_W  base address of the dense vector
- o_mem_req  output  1  read request
- o_mem_addr  output  ADDR_W  read address
- i_mem_gnt  input  1  request accepted
- i_mem_rvalid  input  1  read data valid
- i_mem_rdata  input  16  read data
- o_core_start  output  1  one-cycle start pulse to the core
- i_core_state  input  3  core state (IDLE=0, LOAD=1, MUL=2, ADD=3, WRITE=4)
- o_core_data_A  output  16  matrix value for the current index
- o_core_data_B  output  16  vector value for the current index
- o_core_count  output  8  current nonzero index
- o_core_row_ptr  output  136  latched row pointers
- o_done  output  1  one-cycle job-complete pulse
- o_busy  output  1  job in progress

Behaviour:
- Reset: all outputs 0, o_job_ready=1, FSM=IDLE, buffer pointers 0. Reset mid-job aborts immediately with no pending-request cleanup; the memory side must also be reset.
- Job accept: on i_job_valid && o_job_ready, latch row_ptr and the bases, set count=0 and tile_start=0.
- nnz==0: o_done pulses the next cycle; no memory traffic; back to IDLE.
- Tile end index e is the smallest index >= tile_start with e==nnz-1, or (e!=0 and e%16==0). This matches the core's finish rule, so tiles are 0..16, 17..32, 33..48, ...
- FSM states: IDLE, F_VAL, F_COL, F_VEC, START, RUN, DONE.
- Per tile entry k (index tile_start+k), three reads are issued in order:
  - F_VAL: address val_base+idx; the value goes to buf_A[k].
  - F_COL: address col_base+idx; the column index is rdata[ADDR_W-1:0].
  - F_VEC: address vec_base+col; the element goes to buf_B[k].
- Memory handshake:
  - o_mem_req and o_mem_addr are held until i_mem_gnt.
  - One request is outstanding at a time; the next request is issued only after i_mem_rvalid.
  - Read latency is at least 1 cycle, any value.
- After the last entry of the tile: START.
  - o_core_start=1 for exactly one cycle, only while i_core_state==IDLE; otherwise wait.
  - Then RUN.
- RUN:
  - o_core_data_A = buf_A[count-tile_start] and o_core_data_B = buf_B[count-tile_start], driven combinationally from registers.
  - Each cycle i_core_state==WRITE: count <= count+1.
  - When i_core_state is first seen IDLE after a WRITE: if count==nnz, go to DONE; else tile_start <= count and go to F_VAL.
- DONE: o_done=1 for one cycle, then IDLE with o_job_ready=1.
- o_busy=1 in every state except IDLE.
- o_job_ready=0 whenever o_busy=1; i_job_valid is ignored while busy.
- count is 8-bit with no wrap; nnz<=255 is guaranteed by the row-pointer width.
- o_core_row_ptr holds its value from job accept until the next accept.

Optional Feature:
- SPMV_SCHED_PERF_EN defined: adds outputs o_perf_mem_wait[31:0] and o_perf_run[31:0].
  - o_perf_mem_wait counts cycles with o_mem_req && !i_mem_gnt, plus cycles waiting for rvalid.
  - o_perf_run counts RUN cycles.
  - Both clear on job accept and on i_rst, and saturate at all-ones.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- nnz=0 (row_ptr[135:128]=0) job -> o_done high exactly 1 cycle after accept; zero o_mem_req cycles; core never started.
- nnz=3, val={0x3C00,0x4000,0x4200}, col={0,1,2}, vec={0x3C00,0x3C00,0x4000}, 1-cycle memory -> 9 reads in order, one o_core_start, o_core_count steps 0,1,2 on the WRITE cycles, o_done after the core returns to IDLE.
- nnz=20 -> two tiles: tile 1 has 17 entries (51 reads), tile 2 has 3 entries (9 reads); two o_core_start pulses; final count=20.
- Memory with grant delayed 3 cycles and rvalid latency 2 -> o_mem_addr stable while waiting; never more than 1 outstanding; results identical to the 1-cycle case.
- i_rst asserted during F_COL of tile 2 -> next cycle all outputs 0, o_job_ready=1; a new nnz=1 job completes normally.
- i_job_valid held high through and after a job -> exactly one acceptance per o_job_ready window; no acceptance while o_busy=1.
